recebe_ascii_bcd: RTL and testbench

Serial receiver that decodes two ASCII decimal digits, sent as 7O1 frames (7 data bits, odd parity, 1 stop bit), into one packed 8-bit BCD value. It is the receive-side counterpart of the BCD-to-ASCII transmit path, so the tens digit arrives first and the units digit second. It sits between the board's serial RX pin and the logic that consumes BCD values. The block contains its own bit-timing, frame deserialisation, validation and two-digit assembly.

---
 rtl/recebe_ascii_bcd_if.sv | 25 ++
 rtl/recebe_ascii_bcd.sv | 193 +++++++++++++++++++
 tb/tb_recebe_ascii_bcd.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/recebe_ascii_bcd_if.sv
// Receive-side bundle of the ASCII-to-BCD receiver: serial line in, packed BCD
// value and status pulses out. The master drives the line and the slave is the receiver.
interface recebe_ascii_bcd_if;
   logic       rx_serial;
   logic [7:0] bcd;
   logic       pronto_recepcao_bcd;
   logic       erro_recepcao;
   logic       digito_pendente;

   modport master (
      output rx_serial,
      input  bcd,
      input  pronto_recepcao_bcd,
      input  erro_recepcao,
      input  digito_pendente
   );

   modport slave (
      input  rx_serial,
      output bcd,
      output pronto_recepcao_bcd,
      output erro_recepcao,
      output digito_pendente
   );
endinterface

// File: rtl/recebe_ascii_bcd.sv
// Decodes two 7O1 ASCII decimal characters, tens first, into one packed BCD byte.
// The block contains bit timing, deserialisation, validation and two-digit assembly.
module recebe_ascii_bcd #(
   parameter int CLOCK_FREQ = 50000000,
   parameter int BAUD_RATE  = 115200
) (
   input  logic              clock,
   input  logic              reset,
   recebe_ascii_bcd_if.slave bus
);
   localparam int N     = CLOCK_FREQ / BAUD_RATE;
   localparam int H     = N / 2;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H - 1);

   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      INICIO   = 3'd1,
      DADOS    = 3'd2,
      PARIDADE = 3'd3,
      PARADA   = 3'd4,
      AVALIA   = 3'd5
   } quadro_t;

   typedef enum logic {
      ESPERA_DEZENA  = 1'b0,
      ESPERA_UNIDADE = 1'b1
   } montagem_t;

   function automatic logic paridade_impar_ok(input logic [6:0] dados, input logic par);
      return ^{dados, par};
   endfunction

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             prev_q, prev_d;
   quadro_t          quadro_q, quadro_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [6:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic             stop_q, stop_d;
   montagem_t        mont_q, mont_d;
   logic [3:0]       dezena_q, dezena_d;
   logic [7:0]       bcd_q, bcd_d;
   logic             pronto_q, pronto_d;
   logic             erro_q, erro_d;
   logic             pend_q, pend_d;
   logic             rejeita_s;

   // Next-state logic for synchroniser, frame FSM, digit assembly and outputs
   always_comb begin
      sync1_d   = bus.rx_serial;
      sync2_d   = sync1_q;
      prev_d    = sync2_q;
      quadro_d  = quadro_q;
      cnt_d     = cnt_q + CNT_W'(1);
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_d     = par_q;
      stop_d    = stop_q;
      mont_d    = mont_q;
      dezena_d  = dezena_q;
      bcd_d     = bcd_q;
      pronto_d  = 1'b0;
      erro_d    = 1'b0;
      pend_d    = pend_q;
      rejeita_s = (stop_q == 1'b0) || !paridade_impar_ok(shift_q, par_q) ||
                  (shift_q[6:4] != 3'b011) || (shift_q[3:0] > 4'd9);

      case (quadro_q)
         OCIOSO: begin
            cnt_d = '0;
            if (prev_q && !sync2_q) begin
               quadro_d = INICIO;
            end else begin
               quadro_d = OCIOSO;
            end
         end
         INICIO: begin
            if (cnt_q == H_LAST) begin
               cnt_d = '0;
               bit_d = 3'd0;
               // A line that is high again at mid-start was only a glitch
               if (sync2_q) begin
                  quadro_d = OCIOSO;
               end else begin
                  quadro_d = DADOS;
               end
            end else begin
               quadro_d = INICIO;
            end
         end
         DADOS: begin
            if (cnt_q == N_LAST) begin
               cnt_d   = '0;
               shift_d = {sync2_q, shift_q[6:1]};
               if (bit_q == 3'd6) begin
                  quadro_d = PARIDADE;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               quadro_d = DADOS;
            end
         end
         PARIDADE: begin
            if (cnt_q == N_LAST) begin
               cnt_d    = '0;
               par_d    = sync2_q;
               quadro_d = PARADA;
            end else begin
               quadro_d = PARIDADE;
            end
         end
         PARADA: begin
            if (cnt_q == N_LAST) begin
               cnt_d    = '0;
               stop_d   = sync2_q;
               quadro_d = AVALIA;
            end else begin
               quadro_d = PARADA;
            end
         end
         AVALIA: begin
            cnt_d    = '0;
            quadro_d = OCIOSO;
            if (rejeita_s) begin
               erro_d   = 1'b1;
               mont_d   = ESPERA_DEZENA;
               dezena_d = 4'd0;
               pend_d   = 1'b0;
            end else if (mont_q == ESPERA_DEZENA) begin
               dezena_d = shift_q[3:0];
               mont_d   = ESPERA_UNIDADE;
               pend_d   = 1'b1;
            end else begin
               bcd_d    = {dezena_q, shift_q[3:0]};
               pronto_d = 1'b1;
               mont_d   = ESPERA_DEZENA;
               pend_d   = 1'b0;
            end
         end
         default: begin
            cnt_d    = '0;
            quadro_d = OCIOSO;
         end
      endcase
   end

   // State registers; synchroniser resets high so reset release is not a start edge
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         prev_q   <= 1'b1;
         quadro_q <= OCIOSO;
         cnt_q    <= '0;
         bit_q    <= 3'd0;
         shift_q  <= 7'd0;
         par_q    <= 1'b0;
         stop_q   <= 1'b0;
         mont_q   <= ESPERA_DEZENA;
         dezena_q <= 4'd0;
         bcd_q    <= 8'h00;
         pronto_q <= 1'b0;
         erro_q   <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         prev_q   <= prev_d;
         quadro_q <= quadro_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         stop_q   <= stop_d;
         mont_q   <= mont_d;
         dezena_q <= dezena_d;
         bcd_q    <= bcd_d;
         pronto_q <= pronto_d;
         erro_q   <= erro_d;
         pend_q   <= pend_d;
      end
   end

   assign bus.bcd                 = bcd_q;
   assign bus.pronto_recepcao_bcd = pronto_q;
   assign bus.erro_recepcao       = erro_q;
   assign bus.digito_pendente     = pend_q;
endmodule

// File: tb/tb_recebe_ascii_bcd.sv
// Bench for recebe_ascii_bcd: directed frames from the test plan plus random
// frames, all compared against a character-level reference model.
module tb_recebe_ascii_bcd;
   localparam int N = 50000000 / 115200;
   localparam int H = N / 2;

   logic clk;
   logic rst_n;
   recebe_ascii_bcd_if bus_if ();

   recebe_ascii_bcd #(
      .CLOCK_FREQ (50000000),
      .BAUD_RATE  (115200)
   ) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state, kept at the level of whole characters
   int exp_bcd    = 0;
   int exp_pend   = 0;
   int exp_tens   = 0;
   int exp_pronto = 0;
   int exp_erro   = 0;

   // Monitor state
   int cyc         = 0;
   int mon_pronto  = 0;
   int mon_erro    = 0;
   int mon_both    = 0;
   int mon_badhold = 0;
   int last_pronto = 0;
   int frame_start = 0;
   logic [7:0] prev_bcd = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   // Count output pulses and catch bcd changes that are not announced by pronto
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_if.pronto_recepcao_bcd) begin
            mon_pronto  <= mon_pronto + 1;
            last_pronto <= cyc;
         end
         if (bus_if.erro_recepcao) mon_erro <= mon_erro + 1;
         if (bus_if.pronto_recepcao_bcd && bus_if.erro_recepcao) mon_both <= mon_both + 1;
         if (bus_if.bcd !== prev_bcd && !bus_if.pronto_recepcao_bcd) mon_badhold <= mon_badhold + 1;
      end
      prev_bcd <= bus_if.bcd;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic drive_bit(input logic b);
      bus_if.rx_serial = b;
      repeat (N) @(negedge clk);
   endtask

   task automatic idle(input int cycles);
      bus_if.rx_serial = 1'b1;
      repeat (cycles) @(negedge clk);
   endtask

   // Apply the character rules to the reference model
   task automatic model_frame(input int ch, input bit par_bad, input bit stop_bad);
      if (par_bad || stop_bad || ch < 48 || ch > 57) begin
         exp_erro++;
         exp_pend = 0;
      end else if (exp_pend == 0) begin
         exp_tens = ch - 48;
         exp_pend = 1;
      end else begin
         exp_bcd = exp_tens * 16 + (ch - 48);
         exp_pronto++;
         exp_pend = 0;
      end
   endtask

   task automatic send_frame(input string tag, input logic [6:0] ch, input bit par_bad, input bit stop_bad);
      int ones;
      ones = 0;
      for (int i = 0; i < 7; i++) ones += int'(ch[i]);
      frame_start = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 7; i++) drive_bit(ch[i]);
      drive_bit(((ones % 2) == 0) ^ par_bad);
      drive_bit(!stop_bad);
      bus_if.rx_serial = 1'b1;
      model_frame(int'(ch), par_bad, stop_bad);
      chk({tag, "_bcd"}, 32'(bus_if.bcd), 32'(exp_bcd));
      chk({tag, "_pend"}, 32'(bus_if.digito_pendente), 32'(exp_pend));
      chk({tag, "_npronto"}, 32'(mon_pronto), 32'(exp_pronto));
      chk({tag, "_nerro"}, 32'(mon_erro), 32'(exp_erro));
   endtask

   initial begin
      int lat;
      logic [6:0] rch;
      bit rpar;
      bit rstop;

      rst_n = 1'b0;
      bus_if.rx_serial = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_bcd", 32'(bus_if.bcd), 32'h00);
      chk("rst_pronto", 32'(bus_if.pronto_recepcao_bcd), 32'h0);
      chk("rst_erro", 32'(bus_if.erro_recepcao), 32'h0);
      chk("rst_pend", 32'(bus_if.digito_pendente), 32'h0);
      rst_n = 1'b1;
      idle(20);

      // Basic receive with idle between characters
      send_frame("b4", 7'h34, 1'b0, 1'b0);
      idle(300);
      chk("b4_pend_idle", 32'(bus_if.digito_pendente), 32'h1);
      send_frame("b7", 7'h37, 1'b0, 1'b0);
      idle(50);

      // Back-to-back frames and pronto latency from the second start edge
      send_frame("bb0", 7'h30, 1'b0, 1'b0);
      send_frame("bb9", 7'h39, 1'b0, 1'b0);
      lat = last_pronto - frame_start;
      chk("bb_latency_in_window", 32'((lat >= H + 9 * N + 3) && (lat <= H + 9 * N + 4)), 32'h1);
      idle(50);

      // Parity error drops the held tens digit, then recovery
      send_frame("p1", 7'h31, 1'b0, 1'b0);
      send_frame("p5bad", 7'h35, 1'b1, 1'b0);
      idle(20);
      send_frame("p2", 7'h32, 1'b0, 1'b0);
      send_frame("p3", 7'h33, 1'b0, 1'b0);
      idle(20);

      // Non-digit and framing errors
      send_frame("nA", 7'h41, 1'b0, 1'b0);
      idle(20);
      send_frame("f6", 7'h36, 1'b0, 1'b1);
      idle(50);

      // Glitch rejection
      bus_if.rx_serial = 1'b0;
      repeat (100) @(negedge clk);
      idle(2 * N);
      chk("gl_npronto", 32'(mon_pronto), 32'(exp_pronto));
      chk("gl_nerro", 32'(mon_erro), 32'(exp_erro));
      chk("gl_pend", 32'(bus_if.digito_pendente), 32'(exp_pend));

      // Reset during data bit 3 of the units digit
      send_frame("r3", 7'h33, 1'b0, 1'b0);
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      bus_if.rx_serial = 1'b0;
      repeat (N / 2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mr_bcd", 32'(bus_if.bcd), 32'h00);
      chk("mr_pronto", 32'(bus_if.pronto_recepcao_bcd), 32'h0);
      chk("mr_erro", 32'(bus_if.erro_recepcao), 32'h0);
      chk("mr_pend", 32'(bus_if.digito_pendente), 32'h0);
      exp_bcd  = 0;
      exp_pend = 0;
      @(negedge clk);
      bus_if.rx_serial = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      idle(30);
      send_frame("r5", 7'h35, 1'b0, 1'b0);
      send_frame("r8", 7'h38, 1'b0, 1'b0);
      idle(20);

      // Random characters, corruptions and gaps
      for (int k = 0; k < 4; k++) begin
         if ($urandom_range(1, 0) == 1) rch = 7'(48 + $urandom_range(9, 0));
         else                           rch = 7'($urandom_range(127, 0));
         rpar  = ($urandom_range(5, 0) == 0);
         rstop = ($urandom_range(5, 0) == 0);
         send_frame("rnd", rch, rpar, rstop);
         if (rstop) idle(10 + $urandom_range(40, 0));
         else       idle($urandom_range(40, 0));
      end

      chk("never_both", 32'(mon_both), 32'h0);
      chk("bcd_hold", 32'(mon_badhold), 32'h0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
